// File: rtl/lobster_dbus_arbiter_if.sv
// lobster_dbus_arbiter_if: requester and SRAM command-port signals of the lobster data bus arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters/SRAM side.
interface lobster_dbus_arbiter_if #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64
);
    logic                  fetch_req;
    logic                  load_req;
    logic                  store_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [ADDR_WIDTH-1:0] store_addr;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  fetch_gnt;
    logic                  load_gnt;
    logic                  store_gnt;
    logic                  fetch_valid;
    logic                  load_valid;
    logic                  store_done;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  mem_ce;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rdy;
    logic [1:0]            dbus_mode;
    logic                  busy;

    modport master (
        input  fetch_req, load_req, store_req, fetch_addr, load_addr, store_addr, store_data,
        input  mem_rdata, mem_rdy,
        output fetch_gnt, load_gnt, store_gnt, fetch_valid, load_valid, store_done,
        output rsp_data, rsp_err, mem_ce, mem_we, mem_addr, mem_wdata, dbus_mode, busy
    );

    modport slave (
        output fetch_req, load_req, store_req, fetch_addr, load_addr, store_addr, store_data,
        output mem_rdata, mem_rdy,
        input  fetch_gnt, load_gnt, store_gnt, fetch_valid, load_valid, store_done,
        input  rsp_data, rsp_err, mem_ce, mem_we, mem_addr, mem_wdata, dbus_mode, busy
    );
endinterface

// File: rtl/lobster_dbus_arbiter.sv
// lobster_dbus_arbiter: shares one SRAM command port between fetch, load and store with timeout abort.
// Define LOBSTER_DBUS_RR_EN for round-robin arbitration; otherwise fixed store > load > fetch.
module lobster_dbus_arbiter #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input logic clk,
    input logic rst,
    lobster_dbus_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]            r_state;
    logic [1:0]            r_mode;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            w_req;
    logic                  w_any;
    logic [1:0]            w_win;
    logic [1:0]            w_win_mode;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_abort;

    // requester index: 0 store, 1 load, 2 fetch; bus mode encoding is 3 - index
    assign w_req      = {bus.fetch_req, bus.load_req, bus.store_req};
    assign w_any      = |w_req;
    assign w_win_mode = 2'd3 - w_win;
    assign w_sel_addr = (w_win == 2'd0) ? bus.store_addr : (w_win == 2'd1) ? bus.load_addr : bus.fetch_addr;
    assign w_abort    = (TIMEOUT != 0) && (r_cnt == LAST_WAIT);

`ifdef LOBSTER_DBUS_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_rot;
    logic [1:0] w_j;
    logic [2:0] w_sum;

    // rotate so the current highest-priority requester sits at bit 0
    assign w_rot = (r_ptr == 2'd0) ? w_req[1:0] : (r_ptr == 2'd1) ? w_req[2:1] : {w_req[0], w_req[2]};
    assign w_j   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : 2'd2;
    assign w_sum = 3'(w_j) + 3'(r_ptr);
    assign w_win = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ptr <= 2'd0;
        else if (r_state == S_IDLE && w_any)
            r_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
    end
`else
    assign w_win = w_req[0] ? 2'd0 : w_req[1] ? 2'd1 : 2'd2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_mode          <= 2'b00;
            r_cnt           <= '0;
            bus.fetch_gnt   <= 1'b0;
            bus.load_gnt    <= 1'b0;
            bus.store_gnt   <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.load_valid  <= 1'b0;
            bus.store_done  <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_err     <= 1'b0;
            bus.mem_ce      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.dbus_mode   <= 2'b00;
            bus.busy        <= 1'b0;
        end else begin
            bus.fetch_gnt   <= 1'b0;
            bus.load_gnt    <= 1'b0;
            bus.store_gnt   <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.load_valid  <= 1'b0;
            bus.store_done  <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_err     <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_state       <= S_ACCESS;
                    r_mode        <= w_win_mode;
                    r_cnt         <= '0;
                    bus.store_gnt <= (w_win == 2'd0);
                    bus.load_gnt  <= (w_win == 2'd1);
                    bus.fetch_gnt <= (w_win == 2'd2);
                    bus.mem_ce    <= 1'b1;
                    bus.mem_we    <= (w_win == 2'd0);
                    bus.mem_addr  <= w_sel_addr;
                    bus.mem_wdata <= (w_win == 2'd0) ? bus.store_data : '0;
                    bus.dbus_mode <= w_win_mode;
                    bus.busy      <= 1'b1;
                end
            end else if (r_state == S_ACCESS) begin
                // rdy on the final wait edge still completes without error
                if (bus.mem_rdy || w_abort) begin
                    r_state         <= S_RESP;
                    bus.mem_ce      <= 1'b0;
                    bus.mem_we      <= 1'b0;
                    bus.fetch_valid <= (r_mode == 2'b01);
                    bus.load_valid  <= (r_mode == 2'b10);
                    bus.store_done  <= (r_mode == 2'b11);
                    bus.rsp_data    <= (bus.mem_rdy && r_mode != 2'b11) ? bus.mem_rdata : '0;
                    bus.rsp_err     <= !bus.mem_rdy;
                end else if (TIMEOUT != 0) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_state       <= S_IDLE;
                bus.dbus_mode <= 2'b00;
                bus.busy      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// tb_lobster_dbus_arbiter: scoreboard bench; stimulus pushes expected grants/completions, monitors pop and compare.
module tb_lobster_dbus_arbiter;
    localparam int AW = 36;
    localparam int DW = 64;
    localparam int TO = 4;

    typedef struct {
        logic [1:0]    mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } gnt_t;

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } cpl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_g = 0;
    int wait_n = 0;
    int j = 0;
    int last_len = 0;
    int g_seen = 0;
    logic idle_rdy = 1'b0;
    logic hold = 1'b0;
    logic [DW-1:0] rdata_v = '0;
    gnt_t gq[$];
    cpl_t cq[$];

    lobster_dbus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    lobster_dbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM model: rdy rises after wait_n low ACCESS cycles (never if wait_n < 0)
    always @(negedge clk) begin
        if (!bus.mem_ce) begin
            if (j > 0) last_len = j;
            j = 0;
            bus.mem_rdy = idle_rdy;
        end else begin
            j++;
            bus.mem_rdy = (wait_n >= 0) && (j > wait_n);
        end
        bus.mem_rdata = rdata_v;
    end

    always @(negedge clk) begin : gnt_mon
        logic [1:0] m;
        gnt_t e;
        if (bus.fetch_gnt | bus.load_gnt | bus.store_gnt) begin
            m = {bus.store_gnt | bus.load_gnt, bus.store_gnt | bus.fetch_gnt};
            chk("gnt_onehot", 192'($countones({bus.fetch_gnt, bus.load_gnt, bus.store_gnt})), 1);
            if (gq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL gnt_unexpected: got mode %0b expected none", m);
            end else begin
                e = gq.pop_front();
                chk("gnt_mode", m, e.mode);
                chk("gnt_ce", bus.mem_ce, 1);
                chk("gnt_we", bus.mem_we, e.mode == 2'b11);
                chk("gnt_addr", bus.mem_addr, e.addr);
                chk("gnt_dbus_mode", bus.dbus_mode, e.mode);
                if (e.mode == 2'b11) chk("gnt_wdata", bus.mem_wdata, e.wdata);
                if (e.gap > 0) chk("gnt_gap", cyc - last_g, e.gap);
            end
            last_g = cyc;
        end
    end

    always @(negedge clk) begin : cpl_mon
        logic [1:0] m;
        cpl_t e;
        if (bus.fetch_valid | bus.load_valid | bus.store_done) begin
            m = {bus.store_done | bus.load_valid, bus.store_done | bus.fetch_valid};
            if (cq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cpl_unexpected: got mode %0b expected none", m);
            end else begin
                e = cq.pop_front();
                chk("cpl_mode", m, e.mode);
                chk("cpl_data", bus.rsp_data, e.data);
                chk("cpl_err", bus.rsp_err, e.err);
                chk("cpl_lat", cyc - last_g, e.lat);
                chk("cpl_ce_we", {bus.mem_ce, bus.mem_we}, 0);
                chk("cpl_busy_mode", {bus.busy, bus.dbus_mode}, {1'b1, e.mode});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (bus.fetch_gnt | bus.load_gnt | bus.store_gnt) g_seen++;
        if (!hold) begin
            if (bus.fetch_gnt) bus.fetch_req = 1'b0;
            if (bus.load_gnt) bus.load_req = 1'b0;
            if (bus.store_gnt) bus.store_req = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((gq.size() + cq.size()) != 0 && n < 120) begin
            tick();
            n++;
        end
        chk(name, 192'(gq.size() + cq.size()), 0);
        tick();
        tick();
        chk("idle_after", {bus.busy, bus.mem_ce, bus.dbus_mode}, 0);
    endtask

    function automatic logic [191:0] ctrl_bits();
        return 192'({bus.fetch_gnt, bus.load_gnt, bus.store_gnt, bus.fetch_valid, bus.load_valid,
                     bus.store_done, bus.rsp_err, bus.mem_ce, bus.mem_we, bus.busy, bus.dbus_mode});
    endfunction

    initial begin
        int n;
        int g0;
        logic [1:0] m;
        bus.fetch_req = 0; bus.load_req = 0; bus.store_req = 0;
        bus.fetch_addr = '0; bus.load_addr = '0; bus.store_addr = '0; bus.store_data = '0;
        bus.mem_rdy = 0; bus.mem_rdata = '0;
        // reset held with random requests and rdy high
        idle_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.fetch_req = 1'($urandom); bus.load_req = 1'($urandom); bus.store_req = 1'($urandom);
            tick();
            chk("rst_ctrl", ctrl_bits(), 0);
            chk("rst_data", {bus.mem_addr, bus.mem_wdata, bus.rsp_data}, 0);
        end
        bus.fetch_req = 0; bus.load_req = 0; bus.store_req = 0;
        idle_rdy = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_idle", ctrl_bits(), 0);

        // all three requests: store, load, fetch, 3 cycles apart
        wait_n = 0;
        rdata_v = 64'hA5A5_0000_1234_5678;
        gq.push_back('{2'b11, 36'h0_0000_0200, 64'h1122_3344_5566_7788, 0});
        gq.push_back('{2'b10, 36'h0_0000_0300, 64'h0, 3});
        gq.push_back('{2'b01, 36'h0_0000_0400, 64'h0, 3});
        cq.push_back('{2'b11, 64'h0, 1'b0, 1});
        cq.push_back('{2'b10, 64'hA5A5_0000_1234_5678, 1'b0, 1});
        cq.push_back('{2'b01, 64'hA5A5_0000_1234_5678, 1'b0, 1});
        bus.store_addr = 36'h0_0000_0200; bus.store_data = 64'h1122_3344_5566_7788;
        bus.load_addr = 36'h0_0000_0300; bus.fetch_addr = 36'h0_0000_0400;
        bus.store_req = 1; bus.load_req = 1; bus.fetch_req = 1;
        drain("prio_drain");

        // fetch and load held for 20 grants
        rdata_v = 64'h0F0F_F0F0_0000_0001;
        bus.load_addr = 36'h0_0000_2000; bus.fetch_addr = 36'h0_0000_3000;
        for (int i = 0; i < 20; i++) begin
`ifdef LOBSTER_DBUS_RR_EN
            m = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            m = 2'b10;
`endif
            gq.push_back('{m, (m == 2'b10) ? 36'h0_0000_2000 : 36'h0_0000_3000, 64'h0, (i == 0) ? 0 : 3});
            cq.push_back('{m, 64'h0F0F_F0F0_0000_0001, 1'b0, 1});
        end
        hold = 1'b1;
        bus.load_req = 1; bus.fetch_req = 1;
        g0 = g_seen;
        n = 0;
        while (g_seen < g0 + 20 && n < 200) begin
            tick();
            n++;
        end
        hold = 1'b0;
        bus.load_req = 0; bus.fetch_req = 0;
        drain("arb_drain");

        // load with two wait cycles
        wait_n = 2;
        rdata_v = 64'hDEAD_BEEF_CAFE_F00D;
        bus.load_addr = 36'h0_0000_1000;
        gq.push_back('{2'b10, 36'h0_0000_1000, 64'h0, 0});
        cq.push_back('{2'b10, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3});
        bus.load_req = 1;
        drain("load_drain");
        chk("load_ce_len", 192'(last_len), 3);

        // fetch timeout abort
        wait_n = -1;
        bus.fetch_addr = 36'h0_0000_5000;
        gq.push_back('{2'b01, 36'h0_0000_5000, 64'h0, 0});
        cq.push_back('{2'b01, 64'h0, 1'b1, TO});
        bus.fetch_req = 1;
        drain("timeout_drain");
        chk("timeout_ce_len", 192'(last_len), TO);

        // rdy on the final wait edge wins over the abort
        wait_n = TO - 1;
        rdata_v = 64'h0123_4567_89AB_CDEF;
        gq.push_back('{2'b01, 36'h0_0000_5000, 64'h0, 0});
        cq.push_back('{2'b01, 64'h0123_4567_89AB_CDEF, 1'b0, TO});
        bus.fetch_req = 1;
        drain("edge_rdy_drain");

        // reset during a store wait discards the access
        wait_n = -1;
        bus.store_addr = 36'h0_0000_7000; bus.store_data = 64'hFEED_0000_0000_BEEF;
        gq.push_back('{2'b11, 36'h0_0000_7000, 64'hFEED_0000_0000_BEEF, 0});
        bus.store_req = 1;
        g0 = g_seen;
        n = 0;
        while (g_seen == g0 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_mid_gnt_seen", 192'(g_seen - g0), 1);
        tick();
        chk("rst_mid_active", {bus.mem_ce, bus.mem_we, bus.dbus_mode}, 4'b1111);
        #2 rst = 1'b0;
        #1 chk("rst_mid_ctrl", ctrl_bits(), 0);
        tick();
        tick();
        chk("rst_mid_hold", ctrl_bits(), 0);
        rst = 1'b1;
        wait_n = 1;
        gq.push_back('{2'b11, 36'h0_0000_7000, 64'hFEED_0000_0000_BEEF, 0});
        cq.push_back('{2'b11, 64'h0, 1'b0, 2});
        bus.store_req = 1;
        drain("rerequest_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
